reg_file_mp: RTL

//  Parametrised successor register file for the datapath: 1 write port, NUM_RD registered

---
 rtl/reg_file_mp.sv | 125 ++++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// Parametrised register file with one write port and NUM_RD registered read ports.
// A post-reset sequencer zeroes the whole array before asserting ready.
module reg_file_mp #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       reg_write,
    input  logic [ADDR_W-1:0]          wn,
    input  logic [DATA_W-1:0]          wd,
    input  logic [NUM_RD*ADDR_W-1:0]   rn,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic                       ready,
    output logic [0:0]                 dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_IDLE = 1'b1;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [0:0]        state_q, state_d;
    logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
    logic              ready_q, ready_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wr_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ready_d    = ready_q;
        case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + CNT_ONE;
                if (init_cnt_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ready_q    <= ready_d;
        end
    end

    // A write is only real in IDLE and never to the hardwired-zero entry;
    // the same qualified enable gates the bypass so dropped writes never forward.
    assign wr_en = (state_q == S_IDLE) && reg_write &&
                   !((ZERO_REG != 0) && (wn == '0));

    always_comb begin
        if (state_q == S_INIT) begin
            mem_we   = 1'b1;
            mem_addr = init_cnt_q[ADDR_W-1:0];
            mem_data = '0;
        end else begin
            mem_we   = wr_en;
            mem_addr = wn;
            mem_data = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_q, rd_d;

        assign ra = rn[k*ADDR_W +: ADDR_W];

        always_comb begin
            if (state_q != S_IDLE) begin
                rd_d = '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_d = '0;
            end else if ((BYPASS != 0) && wr_en && (wn == ra)) begin
                rd_d = wd;
            end else begin
                rd_d = mem_q[ra];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rd[k*DATA_W +: DATA_W] = rd_q;
    end

    assign ready     = ready_q;
    assign dbg_state = state_q;

endmodule
